// File: rtl/prime_gen_if.sv
// Control and prime-stream signals of prime_gen: start/limit request,
// valid/ready prime handoff, and run status.
interface prime_gen_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] limit;
  logic             ready;
  logic [WIDTH-1:0] prime;
  logic             valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;

  modport master (
    output start, limit, ready,
    input  prime, valid, busy, done, count
  );

  modport slave (
    input  start, limit, ready,
    output prime, valid, busy, done, count
  );
endinterface

// File: rtl/prime_gen.sv
// Sequential prime enumerator: streams every prime in [2, limit] in ascending
// order, testing each candidate by trial division done as repeated subtraction.
module prime_gen #(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  prime_gen_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SUB   = 3'd2,
    EMIT  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);

  state_t             state;
  logic [WIDTH-1:0]   cand;
  logic [WIDTH-1:0]   div;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   lim;
  logic [2*WIDTH-1:0] div_sq;
  logic [2*WIDTH-1:0] cand_ext;
  logic               last_cand;

  // Double-width square so div*div never overflows near the top of the range
  always_comb begin
    div_sq    = {ZERO, div} * {ZERO, div};
    cand_ext  = {ZERO, cand};
    last_cand = (cand == lim);
  end

  // Enumeration FSM with registered stream and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= ZERO;
      div       <= ZERO;
      rem       <= ZERO;
      lim       <= ZERO;
      bus.prime <= ZERO;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.count <= ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            lim       <= bus.limit;
            bus.count <= ZERO;
            cand      <= TWO;
            div       <= TWO;
            bus.busy  <= 1'b1;
            if (bus.limit < TWO) begin
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (div_sq > cand_ext) begin
            bus.prime <= cand;
            bus.valid <= 1'b1;
            state     <= EMIT;
          end else begin
            rem   <= cand;
            state <= SUB;
          end
        end
        SUB: begin
          if (rem >= div) begin
            rem <= rem - div;
          end else if (rem == ZERO) begin
            state <= NEXT;
          end else begin
            div   <= div + ONE;
            state <= CHECK;
          end
        end
        EMIT: begin
          if (bus.ready) begin
            bus.valid <= 1'b0;
            bus.count <= bus.count + ONE;
            // Stop before incrementing so lim = max value never wraps cand
            if (last_cand) begin
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              cand  <= cand + ONE;
              div   <= TWO;
              state <= CHECK;
            end
          end
        end
        NEXT: begin
          if (last_cand) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            cand  <= cand + ONE;
            div   <= TWO;
            state <= CHECK;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.valid <= 1'b0;
          bus.done  <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
